// File: rtl/salu_branch_issue_arbiter_pkg.sv
// Shared sizing for the SALU/branch issue arbiter.
// Optional macro SALU_BRANCH_ISSUE_PRIORITY_EN (branch-first arbitration) is consumed by the top.
package salu_branch_issue_arbiter_pkg;
    localparam int WF_PER_CU          = 40;
    localparam int WF_ID_LENGTH       = 6;
    localparam int LOCKOUT_CYCLES_DEF = 2;
    localparam int LOCK_CNT_W         = 2;
endpackage

// File: rtl/salu_branch_issue_arbiter_if.sv
// Issue-port bundle between the wavefront side (master) and the arbiter (slave).
interface salu_branch_issue_arbiter_if;
    import salu_branch_issue_arbiter_pkg::*;

    logic [WF_PER_CU-1:0]    ready_arry;
    logic [WF_PER_CU-1:0]    branch_arry;
    logic [WF_PER_CU-1:0]    pending_branches_arry;
    logic                    alu_ready;
    logic                    alu_valid;
    logic                    alu_branch;
    logic [WF_ID_LENGTH-1:0] alu_wfid;
    logic [WF_PER_CU-1:0]    issued_arry;

    modport master (
        output ready_arry, branch_arry, pending_branches_arry, alu_ready,
        input  alu_valid, alu_branch, alu_wfid, issued_arry
    );
    modport slave (
        input  ready_arry, branch_arry, pending_branches_arry, alu_ready,
        output alu_valid, alu_branch, alu_wfid, issued_arry
    );
endinterface

// File: rtl/salu_branch_issue_arbiter_rr_find_first_40.sv
// Combinational round-robin search: first set request after ptr, wrapping, ptr itself last.
module rr_find_first_40
    import salu_branch_issue_arbiter_pkg::*;
(
    input  logic [WF_PER_CU-1:0]    req,
    input  logic [WF_ID_LENGTH-1:0] ptr,
    output logic                    found,
    output logic [WF_ID_LENGTH-1:0] idx
);
    logic [WF_ID_LENGTH:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = WF_PER_CU; k >= 1; k--) begin
            cand = {1'b0, ptr} + (WF_ID_LENGTH+1)'(k);
            if (cand >= (WF_ID_LENGTH+1)'(WF_PER_CU))
                cand = cand - (WF_ID_LENGTH+1)'(WF_PER_CU);
            if (req[cand[WF_ID_LENGTH-1:0]]) begin
                found = 1'b1;
                idx   = cand[WF_ID_LENGTH-1:0];
            end
        end
    end
endmodule

// File: rtl/salu_branch_issue_arbiter.sv
// Picks one wavefront per cycle for the SALU/branch port, masking pending branches and recent issues.
// Define SALU_BRANCH_ISSUE_PRIORITY_EN to prefer eligible branch slots over non-branch slots.
module salu_branch_issue_arbiter
    import salu_branch_issue_arbiter_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
)(
    input  logic                       clk,
    input  logic                       rst,
    salu_branch_issue_arbiter_if.slave bus
);
    logic [WF_PER_CU-1:0][LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [WF_ID_LENGTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [WF_ID_LENGTH-1:0] alu_wfid_q, alu_wfid_d;
    logic                    alu_valid_q, alu_valid_d;
    logic                    alu_branch_q, alu_branch_d;
    logic [WF_PER_CU-1:0]    issued_q, issued_d;

    logic [WF_PER_CU-1:0]    elig;
    logic                    found;
    logic [WF_ID_LENGTH-1:0] winner;
    logic                    issue;

    always_comb begin
        elig = '0;
        for (int i = 0; i < WF_PER_CU; i++)
            elig[i] = bus.ready_arry[i] & ~bus.pending_branches_arry[i] & (lock_cnt_q[i] == '0);
    end

`ifdef SALU_BRANCH_ISSUE_PRIORITY_EN
    logic [WF_PER_CU-1:0]    br_req;
    logic                    found_all, found_br;
    logic [WF_ID_LENGTH-1:0] win_all, win_br;

    assign br_req = elig & bus.branch_arry;

    rr_find_first_40 u_find_all (.req(elig),   .ptr(rr_ptr_q), .found(found_all), .idx(win_all));
    rr_find_first_40 u_find_br  (.req(br_req), .ptr(rr_ptr_q), .found(found_br),  .idx(win_br));

    // Any eligible branch pre-empts plain SALU work; both levels share rr_ptr.
    assign found  = found_all;
    assign winner = found_br ? win_br : win_all;
`else
    rr_find_first_40 u_find_all (.req(elig), .ptr(rr_ptr_q), .found(found), .idx(winner));
`endif

    assign issue = bus.alu_ready & found;

    always_comb begin
        alu_valid_d  = issue;
        alu_branch_d = issue & bus.branch_arry[winner];
        alu_wfid_d   = issue ? winner : alu_wfid_q;
        rr_ptr_d     = issue ? winner : rr_ptr_q;
        issued_d     = '0;
        issued_d[winner] = issue;
        // Reload beats decrement; idle counters stay at zero.
        for (int i = 0; i < WF_PER_CU; i++) begin
            if (issue && (winner == WF_ID_LENGTH'(i)))
                lock_cnt_d[i] = LOCK_CNT_W'(LOCKOUT_CYCLES);
            else if (lock_cnt_q[i] != '0)
                lock_cnt_d[i] = lock_cnt_q[i] - 1'b1;
            else
                lock_cnt_d[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lock_cnt_q   <= '0;
            rr_ptr_q     <= WF_ID_LENGTH'(WF_PER_CU-1);
            alu_wfid_q   <= '0;
            alu_valid_q  <= 1'b0;
            alu_branch_q <= 1'b0;
            issued_q     <= '0;
        end else begin
            lock_cnt_q   <= lock_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            alu_wfid_q   <= alu_wfid_d;
            alu_valid_q  <= alu_valid_d;
            alu_branch_q <= alu_branch_d;
            issued_q     <= issued_d;
        end
    end

    assign bus.alu_valid   = alu_valid_q;
    assign bus.alu_branch  = alu_branch_q;
    assign bus.alu_wfid    = alu_wfid_q;
    assign bus.issued_arry = issued_q;
endmodule

// File: tb/tb_salu_branch_issue_arbiter.sv
// Randomized and directed bench for salu_branch_issue_arbiter against a timestamp-based reference model.
module tb_salu_branch_issue_arbiter;
    import salu_branch_issue_arbiter_pkg::*;

    localparam int LOCK = 2;
    localparam int N    = WF_PER_CU;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    salu_branch_issue_arbiter_if bus();

    salu_branch_issue_arbiter #(.LOCKOUT_CYCLES(LOCK)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Model: rr position plus the cycle each slot last issued; slot free once LOCK cycles have elapsed.
    int   m_rr;
    int   m_last [N];
    int   cyc = 0;
    logic [WF_ID_LENGTH-1:0] m_wfid;
    logic e_valid;
    int   e_win;

    task automatic model_reset();
        m_rr   = N - 1;
        m_wfid = '0;
        for (int i = 0; i < N; i++) m_last[i] = -100;
    endtask

    function automatic logic [N-1:0] bm(input int a);
        logic [N-1:0] m;
        m = '0;
        m[a] = 1'b1;
        return m;
    endfunction

    task automatic step(input logic rn, input logic [N-1:0] rdy, input logic [N-1:0] br,
                        input logic [N-1:0] pend, input logic ar);
        bit el [N];
        bit any_br;
        int win;
        int s;
        logic [N-1:0] oh;
        @(negedge clk);
        rst = rn;
        bus.ready_arry = rdy;
        bus.branch_arry = br;
        bus.pending_branches_arry = pend;
        bus.alu_ready = ar;
        any_br = 0;
        for (int i = 0; i < N; i++) begin
            el[i] = rdy[i] && !pend[i] && (cyc - m_last[i] > LOCK);
            if (el[i] && br[i]) any_br = 1;
        end
`ifndef SALU_BRANCH_ISSUE_PRIORITY_EN
        any_br = 0;
`endif
        win = -1;
        for (int k = 1; k <= N; k++) begin
            s = (m_rr + k) % N;
            if (win < 0 && el[s] && (!any_br || br[s])) win = s;
        end
        @(posedge clk);
        #1;
        oh = '0;
        if (!rn) begin
            model_reset();
            e_valid = 1'b0;
            win = -1;
        end else begin
            e_valid = ar && (win >= 0);
            if (e_valid) begin
                oh[win] = 1'b1;
                m_wfid  = WF_ID_LENGTH'(win);
                m_rr    = win;
                m_last[win] = cyc;
            end
        end
        chk("alu_valid",  bus.alu_valid, e_valid);
        chk("alu_branch", bus.alu_branch, e_valid ? br[win] : 1'b0);
        chk("alu_wfid",   bus.alu_wfid, m_wfid);
        chk("issued",     bus.issued_arry, oh);
        e_win = e_valid ? win : -1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, '0, '0, '0, 1'b0);
    endtask

    logic [N-1:0] ones;
    logic [5:0]   pat;
    int           rr_before;

    initial begin
        ones = '1;
        pat  = 6'b001001;
        bus.ready_arry = '0;
        bus.branch_arry = '0;
        bus.pending_branches_arry = '0;
        bus.alu_ready = 1'b0;
        model_reset();

        step(1'b0, ones, '0, '0, 1'b1);
        step(1'b0, ones, '0, '0, 1'b1);
        chk("reset_valid", bus.alu_valid, 1'b0);
        chk("reset_wfid", bus.alu_wfid, 0);

        // All eligible: strict round robin from slot 0, wrapping back to 0.
        for (int i = 0; i < N + 2; i++) begin
            step(1'b1, ones, '0, '0, 1'b1);
            chk("rr_seq", bus.alu_wfid, i % N);
        end

        idle(3);
        for (int j = 0; j < 6; j++) begin
            step(1'b1, bm(5), '0, '0, 1'b1);
            chk("lock_pat", bus.alu_valid, pat[j]);
            if (pat[j]) chk("lock_wfid", bus.alu_wfid, 5);
        end

        idle(3);
        step(1'b1, bm(3) | bm(7), '0, bm(3), 1'b1);
        chk("pend_mask", bus.alu_wfid, 7);
        step(1'b1, bm(3) | bm(7), '0, '0, 1'b1);
        chk("pend_clear", bus.alu_wfid, 3);

        rr_before = m_rr;
        for (int j = 0; j < 4; j++) begin
            step(1'b1, ones, '0, '0, 1'b0);
            chk("bp_valid", bus.alu_valid, 1'b0);
        end
        step(1'b1, ones, '0, '0, 1'b1);
        chk("bp_resume", bus.alu_wfid, (rr_before + 1) % N);

        idle(3);
        step(1'b1, bm(38), '0, '0, 1'b1);
        idle(3);
        step(1'b1, bm(39) | bm(2), '0, '0, 1'b1);
        chk("wrap_39", bus.alu_wfid, 39);
        step(1'b1, bm(39) | bm(2), '0, '0, 1'b1);
        chk("wrap_2", bus.alu_wfid, 2);

        idle(3);
        step(1'b1, bm(0), '0, '0, 1'b1);
        idle(3);
        step(1'b1, bm(1) | bm(9), bm(9), '0, 1'b1);
`ifdef SALU_BRANCH_ISSUE_PRIORITY_EN
        chk("prio_wfid", bus.alu_wfid, 9);
        chk("prio_br", bus.alu_branch, 1'b1);
`else
        chk("prio_wfid", bus.alu_wfid, 1);
        chk("prio_br", bus.alu_branch, 1'b0);
`endif

        // Reset while issuing drops the issue and restarts the search at slot 0.
        step(1'b1, ones, '0, '0, 1'b1);
        step(1'b0, ones, '0, '0, 1'b1);
        chk("midrst_valid", bus.alu_valid, 1'b0);
        step(1'b1, ones, '0, '0, 1'b1);
        chk("midrst_first", bus.alu_wfid, 0);

        for (int i = 0; i < 500; i++) begin
            logic [N-1:0] r, b, p;
            r = N'({$urandom(), $urandom()});
            b = N'({$urandom(), $urandom()});
            p = N'({$urandom(), $urandom()}) & N'({$urandom(), $urandom()}) & N'({$urandom(), $urandom()});
            if ($urandom_range(0, 3) == 0) r = r & N'({$urandom(), $urandom()}) & N'({$urandom(), $urandom()});
            step($urandom_range(0, 99) != 0, r, b, p, $urandom_range(0, 9) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
